// File: rtl/id_pkg.sv
// Shared encodings for the RV64I decode stage: opcodes, funct3/funct7 codes,
// one-hot control-vector bit positions, the decoded control record and immediate kinds.
package id_pkg;

  localparam int unsigned OP_WIDTH  = 12;
  localparam int unsigned ALU_WIDTH = 10;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_ALUI   = 7'b0010011;
  localparam logic [6:0] OPC_ALUIW  = 7'b0011011;
  localparam logic [6:0] OPC_ALUR   = 7'b0110011;
  localparam logic [6:0] OPC_ALURW  = 7'b0111011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_PRIV   = 3'b000;
  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam int unsigned EP_BRANCH = 0;
  localparam int unsigned EP_JAL    = 1;
  localparam int unsigned EP_JALR   = 2;
  localparam int unsigned EP_LOAD   = 3;
  localparam int unsigned EP_STORE  = 4;
  localparam int unsigned EP_ALUI   = 5;
  localparam int unsigned EP_ALUIW  = 6;
  localparam int unsigned EP_ALUR   = 7;
  localparam int unsigned EP_ALURW  = 8;
  localparam int unsigned EP_LUI    = 9;
  localparam int unsigned EP_AUIPC  = 10;
  localparam int unsigned EP_SYSTEM = 11;

  localparam int unsigned ALU_ADD  = 0;
  localparam int unsigned ALU_SUB  = 1;
  localparam int unsigned ALU_SLL  = 2;
  localparam int unsigned ALU_SLT  = 3;
  localparam int unsigned ALU_SLTU = 4;
  localparam int unsigned ALU_XOR  = 5;
  localparam int unsigned ALU_SRL  = 6;
  localparam int unsigned ALU_SRA  = 7;
  localparam int unsigned ALU_OR   = 8;
  localparam int unsigned ALU_AND  = 9;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_CSR
  } imm_type_t;

  typedef struct packed {
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           dst;
    logic                 need_dst;
    logic [OP_WIDTH-1:0]  epcode;
    logic [ALU_WIDTH-1:0] alu_op;
    logic                 word;
    logic                 illegal;
  } id_ctrl_t;

  // alt selects SUB over ADD and SRA over SRL.
  function automatic logic [ALU_WIDTH-1:0] alu_onehot(input logic [2:0] funct3, input logic alt);
    logic [ALU_WIDTH-1:0] oh;
    oh = '0;
    case (funct3)
      F3_ADD:  oh[alt ? ALU_SUB : ALU_ADD] = 1'b1;
      F3_SLL:  oh[ALU_SLL]  = 1'b1;
      F3_SLT:  oh[ALU_SLT]  = 1'b1;
      F3_SLTU: oh[ALU_SLTU] = 1'b1;
      F3_XOR:  oh[ALU_XOR]  = 1'b1;
      F3_SRL:  oh[alt ? ALU_SRA : ALU_SRL] = 1'b1;
      F3_OR:   oh[ALU_OR]   = 1'b1;
      F3_AND:  oh[ALU_AND]  = 1'b1;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/id_decode_core.sv
// Purely combinational RV64I decoder: instruction -> one-hot control fields,
// illegal flag and sign-extended immediate.
module id_decode_core
  import id_pkg::*;
#(
  parameter int unsigned XLEN = 64,
  parameter int unsigned ILEN = 32
) (
  input  logic [ILEN-1:0] instr_i,
  output id_ctrl_t        ctrl_o,
  output logic [XLEN-1:0] imme_o
);

  logic [6:0]           opcode;
  logic [6:0]           funct7;
  logic [2:0]           funct3;
  logic [4:0]           rd;
  logic                 ill;
  logic                 wr_rd;
  logic                 word;
  imm_type_t            imm_t;
  logic [ALU_WIDTH-1:0] alu;
  logic [OP_WIDTH-1:0]  ep;

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_csr;

  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  always_comb begin
    ill   = 1'b0;
    wr_rd = 1'b0;
    word  = 1'b0;
    imm_t = IMM_NONE;
    alu   = '0;
    ep    = '0;
    case (opcode)
      OPC_BRANCH: begin
        ep[EP_BRANCH] = 1'b1;
        imm_t         = IMM_B;
        case (funct3)
          F3_BEQ, F3_BNE:   alu[ALU_SUB]  = 1'b1;
          F3_BLT, F3_BGE:   alu[ALU_SLT]  = 1'b1;
          F3_BLTU, F3_BGEU: alu[ALU_SLTU] = 1'b1;
          default:          ill           = 1'b1;
        endcase
      end
      OPC_JAL: begin
        ep[EP_JAL]   = 1'b1;
        alu[ALU_ADD] = 1'b1;
        wr_rd        = 1'b1;
        imm_t        = IMM_J;
      end
      OPC_JALR: begin
        ep[EP_JALR]  = 1'b1;
        alu[ALU_ADD] = 1'b1;
        wr_rd        = 1'b1;
        imm_t        = IMM_I;
        ill          = (funct3 != 3'b000);
      end
      OPC_LOAD: begin
        ep[EP_LOAD]  = 1'b1;
        alu[ALU_ADD] = 1'b1;
        wr_rd        = 1'b1;
        imm_t        = IMM_I;
        ill          = (funct3 == 3'b111);
      end
      OPC_STORE: begin
        ep[EP_STORE] = 1'b1;
        alu[ALU_ADD] = 1'b1;
        imm_t        = IMM_S;
        ill          = funct3[2];
      end
      OPC_ALUI: begin
        ep[EP_ALUI] = 1'b1;
        wr_rd       = 1'b1;
        imm_t       = IMM_I;
        case (funct3)
          F3_SLL: begin
            ill = (funct7[6:1] != 6'b000000);
            alu = alu_onehot(funct3, 1'b0);
          end
          F3_SRL: begin
            ill = (funct7[6:1] != 6'b000000) && (funct7[6:1] != 6'b010000);
            alu = alu_onehot(funct3, funct7[5]);
          end
          default: alu = alu_onehot(funct3, 1'b0);
        endcase
      end
      OPC_ALUIW: begin
        ep[EP_ALUIW] = 1'b1;
        wr_rd        = 1'b1;
        word         = 1'b1;
        imm_t        = IMM_I;
        case (funct3)
          F3_ADD: alu = alu_onehot(funct3, 1'b0);
          F3_SLL: begin
            ill = (funct7 != F7_BASE);
            alu = alu_onehot(funct3, 1'b0);
          end
          F3_SRL: begin
            ill = (funct7 != F7_BASE) && (funct7 != F7_ALT);
            alu = alu_onehot(funct3, funct7[5]);
          end
          default: ill = 1'b1;
        endcase
      end
      OPC_ALUR: begin
        ep[EP_ALUR] = 1'b1;
        wr_rd       = 1'b1;
        if (funct7 == F7_BASE)
          alu = alu_onehot(funct3, 1'b0);
        else if ((funct7 == F7_ALT) && (funct3 inside {F3_ADD, F3_SRL}))
          alu = alu_onehot(funct3, 1'b1);
        else
          ill = 1'b1;
      end
      OPC_ALURW: begin
        ep[EP_ALURW] = 1'b1;
        wr_rd        = 1'b1;
        word         = 1'b1;
        if (((funct3 inside {F3_ADD, F3_SRL}) && (funct7 inside {F7_BASE, F7_ALT})) ||
            ((funct3 == F3_SLL) && (funct7 == F7_BASE)))
          alu = alu_onehot(funct3, funct7[5]);
        else
          ill = 1'b1;
      end
      OPC_LUI: begin
        ep[EP_LUI]   = 1'b1;
        alu[ALU_ADD] = 1'b1;
        wr_rd        = 1'b1;
        imm_t        = IMM_U;
      end
      OPC_AUIPC: begin
        ep[EP_AUIPC] = 1'b1;
        alu[ALU_ADD] = 1'b1;
        wr_rd        = 1'b1;
        imm_t        = IMM_U;
      end
      OPC_SYSTEM: begin
        ep[EP_SYSTEM] = 1'b1;
        case (funct3)
          F3_PRIV: imm_t = IMM_I;
          F3_CSRRW, F3_CSRRS, F3_CSRRC: begin
            wr_rd = 1'b1;
            imm_t = IMM_I;
          end
          F3_CSRRWI, F3_CSRRSI, F3_CSRRCI: begin
            wr_rd = 1'b1;
            imm_t = IMM_CSR;
          end
          default: ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase

    if (ill) begin
      alu   = '0;
      ep    = '0;
      wr_rd = 1'b0;
      word  = 1'b0;
      imm_t = IMM_NONE;
    end

    ctrl_o.rs1      = instr_i[19:15];
    ctrl_o.rs2      = instr_i[24:20];
    ctrl_o.dst      = rd;
    ctrl_o.need_dst = wr_rd && (rd != 5'd0);
    ctrl_o.epcode   = ep;
    ctrl_o.alu_op   = alu;
    ctrl_o.word     = word;
    ctrl_o.illegal  = ill;
  end

  assign imm_i   = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
  assign imm_s   = {{(XLEN-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b   = {{(XLEN-13){instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                    instr_i[11:8], 1'b0};
  assign imm_u   = {{(XLEN-32){instr_i[31]}}, instr_i[31:12], 12'b0};
  assign imm_j   = {{(XLEN-21){instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                    instr_i[30:21], 1'b0};
  assign imm_csr = {{(XLEN-5){1'b0}}, instr_i[19:15]};

  assign imme_o = ({XLEN{imm_t == IMM_I}}   & imm_i) |
                  ({XLEN{imm_t == IMM_S}}   & imm_s) |
                  ({XLEN{imm_t == IMM_B}}   & imm_b) |
                  ({XLEN{imm_t == IMM_U}}   & imm_u) |
                  ({XLEN{imm_t == IMM_J}}   & imm_j) |
                  ({XLEN{imm_t == IMM_CSR}} & imm_csr);

endmodule

// File: rtl/id_queue_stage.sv
// RV64I decode stage: DEPTH-entry in-order fetch queue feeding a registered decode output.
// Define ID_BYPASS_EN to let an input skip an empty queue straight into the output register.
module id_queue_stage
  import id_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned ILEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 F_valid_i,
  output logic                 F_ready_o,
  input  logic [XLEN-1:0]      F_pc_i,
  input  logic [ILEN-1:0]      F_instr_i,
  output logic                 D_valid_o,
  input  logic                 E_ready_i,
  output logic [XLEN-1:0]      D_pc_o,
  output logic [4:0]           D_rs1_o,
  output logic [4:0]           D_rs2_o,
  output logic [4:0]           D_dstE_o,
  output logic                 D_need_dstE_o,
  output logic [OP_WIDTH-1:0]  D_epcode_o,
  output logic [ALU_WIDTH-1:0] D_ALU_op_o,
  output logic                 D_word_o,
  output logic [XLEN-1:0]      D_imme_o,
  output logic                 D_illegal_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [XLEN-1:0]  pc_mem_q    [DEPTH];
  logic [XLEN-1:0]  pc_mem_d    [DEPTH];
  logic [ILEN-1:0]  instr_mem_q [DEPTH];
  logic [ILEN-1:0]  instr_mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             d_valid_q, d_valid_d;
  logic [XLEN-1:0]  d_pc_q, d_pc_d;
  id_ctrl_t         d_ctrl_q, d_ctrl_d;
  logic [XLEN-1:0]  d_imme_q, d_imme_d;

  logic             full, empty, accept, load_en, bypass, push, pop;
  logic [XLEN-1:0]  dec_pc;
  logic [ILEN-1:0]  dec_instr;
  id_ctrl_t         dec_ctrl;
  logic [XLEN-1:0]  dec_imme;

  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);
  assign F_ready_o = !full && !rst_i;
  assign accept    = F_valid_i && F_ready_o && !flush_i;
  assign load_en   = !d_valid_q || E_ready_i;

`ifdef ID_BYPASS_EN
  assign bypass = accept && empty && load_en;
`else
  assign bypass = 1'b0;
`endif

  assign push = accept && !bypass;
  assign pop  = load_en && !empty && !flush_i;

  // Decoder sees the queue head, or the live input only when the queue is empty (bypass case).
  assign dec_pc    = empty ? F_pc_i    : pc_mem_q[rd_ptr_q];
  assign dec_instr = empty ? F_instr_i : instr_mem_q[rd_ptr_q];

  id_decode_core #(
    .XLEN(XLEN),
    .ILEN(ILEN)
  ) u_decode (
    .instr_i(dec_instr),
    .ctrl_o (dec_ctrl),
    .imme_o (dec_imme)
  );

  always_comb begin
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    d_valid_d   = d_valid_q;
    d_pc_d      = d_pc_q;
    d_ctrl_d    = d_ctrl_q;
    d_imme_d    = d_imme_q;

    if (push) begin
      pc_mem_d[wr_ptr_q]    = F_pc_i;
      instr_mem_d[wr_ptr_q] = F_instr_i;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (pop || bypass) begin
      d_valid_d = 1'b1;
      d_pc_d    = dec_pc;
      d_ctrl_d  = dec_ctrl;
      d_imme_d  = dec_imme;
    end else if (load_en) begin
      d_valid_d = 1'b0;
    end

    if (flush_i) begin
      count_d   = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      d_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      d_valid_q <= 1'b0;
      d_pc_q    <= '0;
      d_ctrl_q  <= '0;
      d_imme_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      d_valid_q <= d_valid_d;
      d_pc_q    <= d_pc_d;
      d_ctrl_q  <= d_ctrl_d;
      d_imme_q  <= d_imme_d;
    end
  end

  always_ff @(posedge clk_i) begin
    pc_mem_q    <= pc_mem_d;
    instr_mem_q <= instr_mem_d;
  end

  assign D_valid_o     = d_valid_q;
  assign D_pc_o        = d_pc_q;
  assign D_rs1_o       = d_ctrl_q.rs1;
  assign D_rs2_o       = d_ctrl_q.rs2;
  assign D_dstE_o      = d_ctrl_q.dst;
  assign D_need_dstE_o = d_ctrl_q.need_dst;
  assign D_epcode_o    = d_ctrl_q.epcode;
  assign D_ALU_op_o    = d_ctrl_q.alu_op;
  assign D_word_o      = d_ctrl_q.word;
  assign D_imme_o      = d_imme_q;
  assign D_illegal_o   = d_ctrl_q.illegal;

endmodule

// File: tb/tb_id_queue_stage.sv
// Self-checking bench for id_queue_stage: table-driven decode vectors plus
// hand-written queue, back-pressure, flush and reset sequences.
module tb_id_queue_stage;
  import id_pkg::*;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
`ifdef ID_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic                 clk_i = 1'b0;
  logic                 rst_i, flush_i, F_valid_i, E_ready_i;
  logic                 F_ready_o, D_valid_o;
  logic [XLEN-1:0]      F_pc_i, D_pc_o, D_imme_o;
  logic [ILEN-1:0]      F_instr_i;
  logic [4:0]           D_rs1_o, D_rs2_o, D_dstE_o;
  logic                 D_need_dstE_o, D_word_o, D_illegal_o;
  logic [OP_WIDTH-1:0]  D_epcode_o;
  logic [ALU_WIDTH-1:0] D_ALU_op_o;

  int n_chk  = 0;
  int n_fail = 0;

  id_queue_stage #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .F_valid_i(F_valid_i), .F_ready_o(F_ready_o), .F_pc_i(F_pc_i), .F_instr_i(F_instr_i),
    .D_valid_o(D_valid_o), .E_ready_i(E_ready_i), .D_pc_o(D_pc_o),
    .D_rs1_o(D_rs1_o), .D_rs2_o(D_rs2_o), .D_dstE_o(D_dstE_o), .D_need_dstE_o(D_need_dstE_o),
    .D_epcode_o(D_epcode_o), .D_ALU_op_o(D_ALU_op_o), .D_word_o(D_word_o),
    .D_imme_o(D_imme_o), .D_illegal_o(D_illegal_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [31:0]          instr;
    logic                 illegal;
    logic [ALU_WIDTH-1:0] alu;
    logic [OP_WIDTH-1:0]  ep;
    logic                 word;
    logic                 need;
    logic [63:0]          imm;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           dst;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [ALU_WIDTH-1:0] aoh(input int unsigned i);
    logic [ALU_WIDTH-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [OP_WIDTH-1:0] eoh(input int unsigned i);
    logic [OP_WIDTH-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  function automatic vec_t mkv(input logic [31:0] instr, input logic ill,
                               input logic [ALU_WIDTH-1:0] alu, input logic [OP_WIDTH-1:0] ep,
                               input logic word, input logic need, input logic [63:0] imm,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] dst);
    vec_t v;
    v.instr = instr; v.illegal = ill; v.alu = alu; v.ep = ep; v.word = word;
    v.need = need; v.imm = imm; v.rs1 = rs1; v.rs2 = rs2; v.dst = dst;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [63:0] pc, input logic [31:0] instr);
    F_valid_i = 1'b1;
    F_pc_i    = pc;
    F_instr_i = instr;
  endtask

  task automatic wait_valid(input string name);
    int w;
    w = 0;
    while (!D_valid_o && w < 6) begin
      tick();
      w++;
    end
    chk(name, 64'(D_valid_o), 64'd1);
  endtask

  initial begin
    vecs[0]  = mkv(32'hFFF00293, 0, aoh(ALU_ADD), eoh(EP_ALUI),   0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 31, 5);
    vecs[1]  = mkv(32'h0000007F, 1, '0,           '0,             0, 0, 64'h0,                  0, 0, 0);
    vecs[2]  = mkv(32'h42115193, 0, aoh(ALU_SRA), eoh(EP_ALUI),   0, 1, 64'h421,                2, 1, 3);
    vecs[3]  = mkv(32'h003110BB, 0, aoh(ALU_SLL), eoh(EP_ALURW),  1, 1, 64'h0,                  2, 3, 1);
    vecs[4]  = mkv(32'h123453B7, 0, aoh(ALU_ADD), eoh(EP_LUI),    0, 1, 64'h1234_5000,          8, 3, 7);
    vecs[5]  = mkv(32'h40208033, 0, aoh(ALU_SUB), eoh(EP_ALUR),   0, 0, 64'h0,                  1, 2, 0);
    vecs[6]  = mkv(32'h03F09093, 0, aoh(ALU_SLL), eoh(EP_ALUI),   0, 1, 64'h3F,                 1, 31, 1);
    vecs[7]  = mkv(32'h0200909B, 1, '0,           '0,             0, 0, 64'h0,                  1, 0, 1);
    vecs[8]  = mkv(32'hFE512C23, 0, aoh(ALU_ADD), eoh(EP_STORE),  0, 0, 64'hFFFF_FFFF_FFFF_FFF8, 2, 5, 24);
    vecs[9]  = mkv(32'h008000EF, 0, aoh(ALU_ADD), eoh(EP_JAL),    0, 1, 64'h8,                  0, 8, 1);
    vecs[10] = mkv(32'h3002D0F3, 0, '0,           eoh(EP_SYSTEM), 0, 1, 64'h5,                  5, 0, 1);
    vecs[11] = mkv(32'hFE2088E3, 0, aoh(ALU_SUB), eoh(EP_BRANCH), 0, 0, 64'hFFFF_FFFF_FFFF_FFF0, 1, 2, 17);
    vecs[12] = mkv(32'h40209033, 1, '0,           '0,             0, 0, 64'h0,                  1, 2, 0);
    vecs[13] = mkv(32'h00004073, 1, '0,           '0,             0, 0, 64'h0,                  0, 0, 0);
    vecs[14] = mkv(32'h80000517, 0, aoh(ALU_ADD), eoh(EP_AUIPC),  0, 1, 64'hFFFF_FFFF_8000_0000, 0, 0, 10);
    vecs[15] = mkv(32'h01013183, 0, aoh(ALU_ADD), eoh(EP_LOAD),   0, 1, 64'h10,                 2, 16, 3);

    rst_i = 1'b1; flush_i = 1'b0; F_valid_i = 1'b0; E_ready_i = 1'b1;
    F_pc_i = '0; F_instr_i = '0;
    tick(); tick();
    chk("rst_valid", 64'(D_valid_o), 64'd0);
    chk("rst_ready", 64'(F_ready_o), 64'd0);
    rst_i = 1'b0;
    #1;
    chk("rst_ready_rel", 64'(F_ready_o), 64'd1);
    chk("rst_pc", D_pc_o, 64'd0);
    chk("rst_imme", D_imme_o, 64'd0);
    chk("rst_alu", 64'(D_ALU_op_o), 64'd0);
    chk("rst_ep", 64'(D_epcode_o), 64'd0);

    // Latency: accepted at edge N, valid after edge N+LAT-1.
    drive(64'h1000, 32'hFFF00293);
    for (int c = 1; c <= LAT; c++) begin
      tick();
      F_valid_i = 1'b0;
      chk($sformatf("lat_c%0d", c), 64'(D_valid_o), (c == LAT) ? 64'd1 : 64'd0);
    end
    chk("lat_pc", D_pc_o, 64'h1000);
    chk("lat_imme", D_imme_o, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    chk("lat_drain", 64'(D_valid_o), 64'd0);

    for (int i = 0; i < 16; i++) begin
      drive(64'h2000 + 64'(i * 4), vecs[i].instr);
      tick();
      F_valid_i = 1'b0;
      wait_valid($sformatf("v%0d_valid", i));
      chk($sformatf("v%0d_pc", i), D_pc_o, 64'h2000 + 64'(i * 4));
      chk($sformatf("v%0d_illegal", i), 64'(D_illegal_o), 64'(vecs[i].illegal));
      chk($sformatf("v%0d_alu", i), 64'(D_ALU_op_o), 64'(vecs[i].alu));
      chk($sformatf("v%0d_ep", i), 64'(D_epcode_o), 64'(vecs[i].ep));
      chk($sformatf("v%0d_word", i), 64'(D_word_o), 64'(vecs[i].word));
      chk($sformatf("v%0d_need", i), 64'(D_need_dstE_o), 64'(vecs[i].need));
      chk($sformatf("v%0d_imm", i), D_imme_o, vecs[i].imm);
      chk($sformatf("v%0d_rs1", i), 64'(D_rs1_o), 64'(vecs[i].rs1));
      chk($sformatf("v%0d_rs2", i), 64'(D_rs2_o), 64'(vecs[i].rs2));
      chk($sformatf("v%0d_dst", i), 64'(D_dstE_o), 64'(vecs[i].dst));
      tick();
    end

    // Back-pressure: 4 queued + 1 held, then drain in order.
    E_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_ready%0d", k), 64'(F_ready_o), 64'd1);
      drive(64'(k * 4), 32'h00000013);
      tick();
    end
    drive(64'h99, 32'h00000013);
    chk("bp_full", 64'(F_ready_o), 64'd0);
    tick();
    chk("bp_held_pc", D_pc_o, 64'd0);
    F_valid_i = 1'b0;
    E_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_out%0d_valid", k), 64'(D_valid_o), 64'd1);
      chk($sformatf("bp_out%0d_pc", k), D_pc_o, 64'(k * 4));
      tick();
    end
    chk("bp_empty", 64'(D_valid_o), 64'd0);

    // Flush with 3 queued + valid output and a live offer.
    E_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(64'd100 + 64'(k * 4), 32'h00000013);
      tick();
    end
    F_valid_i = 1'b0;
    chk("fl_pre_valid", 64'(D_valid_o), 64'd1);
    chk("fl_pre_pc", D_pc_o, 64'd100);
    chk("fl_pre_full", 64'(F_ready_o), 64'd1);
    flush_i = 1'b1;
    drive(64'd200, 32'h00000013);
    tick();
    flush_i = 1'b0;
    F_valid_i = 1'b0;
    chk("fl_valid", 64'(D_valid_o), 64'd0);
    chk("fl_ready", 64'(F_ready_o), 64'd1);
    E_ready_i = 1'b1;
    tick(); tick(); tick();
    chk("fl_stays_empty", 64'(D_valid_o), 64'd0);
    drive(64'd300, 32'h00000013);
    tick();
    F_valid_i = 1'b0;
    wait_valid("fl_post_valid");
    chk("fl_post_pc", D_pc_o, 64'd300);
    tick();
    chk("fl_post_drain", 64'(D_valid_o), 64'd0);

    // Reset mid-operation clears queue and output register.
    E_ready_i = 1'b0;
    drive(64'd400, 32'hFFF00293);
    tick();
    drive(64'd404, 32'h00000013);
    tick();
    F_valid_i = 1'b0;
    chk("mr_pre_valid", 64'(D_valid_o), 64'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("mr_valid", 64'(D_valid_o), 64'd0);
    chk("mr_pc", D_pc_o, 64'd0);
    chk("mr_imme", D_imme_o, 64'd0);
    chk("mr_need", 64'(D_need_dstE_o), 64'd0);
    E_ready_i = 1'b1;
    tick(); tick();
    chk("mr_stays_empty", 64'(D_valid_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
